// File: rtl/bm_rx_pkg.sv
// Shared types and constants for the processor output-port receiver.
package bm_rx_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;
    localparam int unsigned RxCountWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StWaitLow
    } rx_state_e;

endpackage

// File: rtl/bm_rx_fifo.sv
// Power-of-two circular FIFO with occupancy count; pops on empty and pushes on full are dropped.
module bm_rx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clock_signal,
    input  logic                     reset_signal,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthLvl = {1'b1, {AddrW{1'b0}}};

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == DepthLvl);
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clock_signal) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

endmodule

// File: rtl/bm_out_receiver.sv
// Receives words from a processor output port (valid level / received pulse) into a FIFO.
// Define BM_RX_STATS_EN to add the saturating rx_count write counter.
module bm_out_receiver
    import bm_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                    clock_signal,
    input  logic                    reset_signal,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_received,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level
`ifdef BM_RX_STATS_EN
    ,
    output logic [RxCountWidth-1:0] rx_count
`endif
);

    rx_state_e state_q, state_d;
    logic      push;
    logic      full;
    logic      empty;

    always_ff @(posedge clock_signal) begin
        if (reset_signal) state_q <= StIdle;
        else              state_q <= state_d;
    end

    // Full is the registered flag, so a same-cycle pop never unblocks a write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (in_valid && !full) state_d = StAck;
            StAck:     state_d = StWaitLow;
            StWaitLow: if (!in_valid) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        push        = (state_q == StIdle) && in_valid && !full;
        in_received = (state_q == StAck);
    end

    bm_rx_fifo #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_fifo (
        .clock_signal (clock_signal),
        .reset_signal (reset_signal),
        .push         (push),
        .push_data    (in_data),
        .pop          (out_ready),
        .head_data    (out_data),
        .full         (full),
        .empty        (empty),
        .level        (level)
    );

    assign out_valid = !empty;

`ifdef BM_RX_STATS_EN
    logic [RxCountWidth-1:0] rx_count_q;

    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            rx_count_q <= '0;
        end else if (push && (rx_count_q != '1)) begin
            rx_count_q <= rx_count_q + 1'b1;
        end
    end

    assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_bm_out_receiver.sv
// Directed bench for bm_out_receiver: vector table plus handshake, wrap and reset sequences.
module tb_bm_out_receiver;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_received;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
`ifdef BM_RX_STATS_EN
    logic [15:0] rx_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bm_out_receiver #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clock_signal (clk),
        .reset_signal (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_received  (in_received),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level)
`ifdef BM_RX_STATS_EN
        ,
        .rx_count     (rx_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       v;
        logic       rdy;
        logic       e_recv;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [7:0] d, input logic v, input logic rdy,
                       input logic e_recv, input logic e_ov, input logic [7:0] e_od,
                       input logic [2:0] e_lvl);
        vec_t x;
        x.rst = r; x.d = d; x.v = v; x.rdy = rdy;
        x.e_recv = e_recv; x.e_ov = e_ov; x.e_od = e_od; x.e_lvl = e_lvl;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        int n;
        n = 0;
        in_data = d;
        in_valid = 1'b1;
        while (!in_received && n < 20) begin
            tick();
            n++;
        end
        if (!in_received) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got no in_received expected a pulse for %0h", d);
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int pulses;
        int sent;
        int got;
        int low;
        int cyc;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

        // Single word, pop, pop-on-empty.
        add(1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        add(0, 8'hA5, 1, 0, 1, 1, 8'hA5, 1);
        add(0, 8'hA5, 1, 0, 0, 1, 8'hA5, 1);
        add(0, 8'h00, 0, 0, 0, 1, 8'hA5, 1);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0);
        // Fill to DEPTH with words 1..4.
        for (int k = 1; k <= 4; k++) begin
            add(0, 8'(k), 1, 0, 1, 1, 8'h01, 3'(k));
            add(0, 8'h00, 0, 0, 0, 1, 8'h01, 3'(k));
            add(0, 8'h00, 0, 0, 0, 1, 8'h01, 3'(k));
        end
        // Fifth word blocked while full; one pop, then captured on the next cycle.
        add(0, 8'h05, 1, 0, 0, 1, 8'h01, 4);
        add(0, 8'h05, 1, 0, 0, 1, 8'h01, 4);
        add(0, 8'h05, 1, 1, 0, 1, 8'h02, 3);
        add(0, 8'h05, 1, 0, 1, 1, 8'h02, 4);
        add(0, 8'h05, 0, 0, 0, 1, 8'h02, 4);
        add(0, 8'h00, 0, 0, 0, 1, 8'h02, 4);
        // Drain and confirm order 3,4,5.
        add(0, 8'h00, 0, 1, 0, 1, 8'h03, 3);
        add(0, 8'h00, 0, 1, 0, 1, 8'h04, 2);
        add(0, 8'h00, 0, 1, 0, 1, 8'h05, 1);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_data = vecs[i].d; in_valid = vecs[i].v;
            out_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_recv", i), 32'(in_received), 32'(vecs[i].e_recv));
            check($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_lvl", i), 32'(level), 32'(vecs[i].e_lvl));
            if (vecs[i].e_ov)
                check($sformatf("v%0d_od", i), 32'(out_data), 32'(vecs[i].e_od));
        end

        // Held valid with changing data yields one word, one pulse.
        do_reset();
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            tick();
            if (in_received) pulses++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_level", 32'(level), 32'd1);
        check("held_data", 32'(out_data), 32'h01);

        // Stream 20 words with out_ready toggling; check order and level bound.
        do_reset();
        sent = 0; got = 0; low = 0; cyc = 0;
        in_data = 8'h30; in_valid = 1'b1;
        while (got < 20 && cyc < 2000) begin
            out_ready = cyc[0];
            if (out_valid && out_ready) begin
                check($sformatf("wrap_word%0d", got), 32'(out_data), 32'(8'h30 + got));
                got++;
            end
            tick();
            cyc++;
            if (level > 3'd4) check("wrap_level_max", 32'(level), 32'd4);
            if (in_received) begin
                sent++;
                in_valid = 1'b0;
                low = 2;
            end else if (low > 0) begin
                low--;
                if (low == 0 && sent < 20) begin
                    in_data = 8'(8'h30 + sent);
                    in_valid = 1'b1;
                end
            end
        end
        check("wrap_count", 32'(got), 32'd20);
        out_ready = 1'b0;

        // Reset during ACK abandons the transfer; held valid is recaptured after release.
        do_reset();
        in_data = 8'h77; in_valid = 1'b1;
        tick();
        check("rst_ack_recv", 32'(in_received), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_recv", 32'(in_received), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_recap_recv", 32'(in_received), 32'd1);
        check("rst_recap_level", 32'(level), 32'd1);
        check("rst_recap_data", 32'(out_data), 32'h77);
        in_valid = 1'b0;
        tick();
        tick();

`ifdef BM_RX_STATS_EN
        do_reset();
        check("stats_reset", 32'(rx_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(8'(i + 1));
        check("stats_three", 32'(rx_count), 32'd3);
        dut.rx_count_q = 16'hFFFE;
        for (int i = 0; i < 3; i++) push_word(8'(i + 4));
        check("stats_saturate", 32'(rx_count), 32'hFFFF);
        out_ready = 1'b0;
`else
        do_reset();
        out_ready = 1'b0;
        push_word(8'h5A);
        check("push_task_level", 32'(level), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
